// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two NIBBLES*4-bit operands through a single 4-bit ripple-carry stage,
//   one nibble per clock, LSB nibble first. Operands are latched on the
//   accepting edge. The carry register is the only path between nibbles. The
//   result is published all at once on the edge that raises done.
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset
//   start  : sum request, sampled when busy==0
//   A, B   : W-bit operands, sampled on the accepting edge
//   cin    : carry into nibble 0, sampled with A/B
//   busy   : high while a sum is in progress
//   done   : one-cycle pulse; S/cout/ovf update on the same edge
//   S      : registered W-bit sum, holds until the next done
//   cout   : unsigned carry out of the MSB nibble
//   ovf    : two's-complement overflow of A+B+cin
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned IDX_W = CNT_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_shadow;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic [4:0]       w_chain;
  logic             w_cout;
  logic             w_last;
  logic [W-1:0]     w_final;
  logic             w_ovf;

  // Bit offset of the nibble currently being processed.
  assign w_idx   = {r_cnt, 2'b00};
  assign w_a_nib = r_a[w_idx +: 4];
  assign w_b_nib = r_b[w_idx +: 4];

  // The single 4-bit ripple-carry adder stage.
  always_comb begin
    w_chain    = '0;
    w_sum      = '0;
    w_chain[0] = r_carry;
    for (int i = 0; i < 4; i++) begin
      w_sum[i]     = w_a_nib[i] ^ w_b_nib[i] ^ w_chain[i];
      w_chain[i+1] = (w_a_nib[i] & w_b_nib[i]) | (w_chain[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end
  end
  assign w_cout = w_chain[4];

  assign w_last = (r_cnt == CNT_W'(NIBBLES - 1));

  // Completed sum: lower nibbles from the shadow, top nibble straight from the adder.
  always_comb begin
    w_final            = r_shadow;
    w_final[W-1 -: 4]  = w_sum;
  end

  assign w_ovf = (r_a[W-1] == r_b[W-1]) && (w_sum[3] != r_a[W-1]);

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // DONE accepts a new start exactly like IDLE for back-to-back sums.
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_shadow[w_idx +: 4] <= w_sum;
          r_carry              <= w_cout;
          r_cnt                <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_s     <= w_final;
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
